// File: rtl/div_pkg.sv
// Shared types and constants for the divider request/response front-end.
// Holds the state encoding, default sizes and the divide-by-zero quotient.
package div_pkg;

    localparam int DIV_WIDTH   = 16;
    localparam int DIV_TIMEOUT = 64;

    localparam logic [DIV_WIDTH-1:0] DIV_DZ_QUOTIENT = '1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_WAIT    = 3'd2,
        ST_RESP    = 3'd3,
        ST_RELEASE = 3'd4
    } div_state_e;

endpackage

// File: rtl/div_watchdog.sv
// Counter that supervises the core while the front-end waits for DONE.
// o_expired is high on the last allowed WAIT cycle.
module div_watchdog #(
    parameter int CW    = 7,
    parameter int LIMIT = 64
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    logic [CW-1:0] r_count;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_expired = (r_count == CW'(LIMIT - 1));

endmodule

// File: rtl/div_req_if.sv
// Valid/ready front-end for the shift-subtract divider core: issues work,
// handles divide-by-zero locally, aborts a hung core, and re-arms it after use.
//
// state   | meaning
// IDLE    | ready for a request, operands captured on accept
// ISSUE   | start pulse to the core, watchdog cleared
// WAIT    | waiting for core DONE or watchdog expiry
// RESP    | result presented until consumer accepts
// RELEASE | start pulse that returns the core from END to START
module div_req_if
    import div_pkg::*;
#(
    parameter int WIDTH   = DIV_WIDTH,
    parameter int TIMEOUT = DIV_TIMEOUT,
    parameter int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_dividend,
    input  logic [WIDTH-1:0] req_divisor,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_quotient,
    output logic [WIDTH-1:0] resp_remainder,
    output logic             resp_dz,
    output logic             resp_timeout,
    output logic [WIDTH-1:0] core_dividend,
    output logic [WIDTH-1:0] core_divisor,
    output logic             core_start,
    output logic             core_clr,
    input  logic             core_done,
    input  logic [WIDTH-1:0] core_quotient,
    input  logic [WIDTH-1:0] core_remainder
);

    localparam logic [WIDTH-1:0] DZ_Q = {WIDTH{DIV_DZ_QUOTIENT[0]}};

    div_state_e       r_state;
    div_state_e       w_next;
    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_dz;
    logic             r_timeout;
    logic             r_core_clr;
    logic             w_expired;

    div_watchdog #(
        .CW    (CW),
        .LIMIT (TIMEOUT)
    ) u_watchdog (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_clr     (r_state == ST_ISSUE),
        .i_en      (r_state == ST_WAIT),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (req_valid) w_next = (req_divisor == '0) ? ST_RESP : ST_ISSUE;
            ST_ISSUE:   w_next = ST_WAIT;
            ST_WAIT:    if (core_done || w_expired) w_next = ST_RESP;
            // dz and timeout paths leave the core already in START
            ST_RESP:    if (resp_ready) w_next = (r_dz || r_timeout) ? ST_IDLE : ST_RELEASE;
            ST_RELEASE: w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = (r_state == ST_IDLE);
        resp_valid = (r_state == ST_RESP);
        core_start = (r_state == ST_ISSUE) || (r_state == ST_RELEASE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_dz        <= 1'b0;
            r_timeout   <= 1'b0;
            r_core_clr  <= 1'b0;
        end else begin
            r_core_clr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_dividend <= req_dividend;
                        r_divisor  <= req_divisor;
                        r_timeout  <= 1'b0;
                        if (req_divisor == '0) begin
                            r_quotient  <= DZ_Q;
                            r_remainder <= req_dividend;
                            r_dz        <= 1'b1;
                        end else begin
                            r_dz <= 1'b0;
                        end
                    end
                end
                ST_WAIT: begin
                    // DONE takes priority over a coincident expiry
                    if (core_done) begin
                        r_quotient  <= core_quotient;
                        r_remainder <= core_remainder;
                        r_dz        <= 1'b0;
                        r_timeout   <= 1'b0;
                    end else if (w_expired) begin
                        r_quotient  <= '0;
                        r_remainder <= '0;
                        r_dz        <= 1'b0;
                        r_timeout   <= 1'b1;
                        r_core_clr  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign resp_quotient  = r_quotient;
    assign resp_remainder = r_remainder;
    assign resp_dz        = r_dz;
    assign resp_timeout   = r_timeout;
    assign core_dividend  = r_dividend;
    assign core_divisor   = r_divisor;
    assign core_clr       = r_core_clr;

endmodule

// File: tb/tb_div_req_if.sv
// Directed bench for div_req_if with a behavioural divider core model.
// Inputs are driven and outputs sampled 1ns after the rising edge.
module tb_div_req_if;

    localparam int W       = 16;
    localparam int TIMEOUT = 64;
    localparam int CORE_LAT = 40;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [W-1:0] req_dividend;
    logic [W-1:0] req_divisor;
    logic         resp_valid;
    logic         resp_ready;
    logic [W-1:0] resp_quotient;
    logic [W-1:0] resp_remainder;
    logic         resp_dz;
    logic         resp_timeout;
    logic [W-1:0] core_dividend;
    logic [W-1:0] core_divisor;
    logic         core_start;
    logic         core_clr;
    logic         core_done;
    logic [W-1:0] core_quotient;
    logic [W-1:0] core_remainder;

    int checks   = 0;
    int failures = 0;
    int n_start  = 0;
    int base;
    int k;

    // behavioural core model
    logic         m_busy;
    logic         m_never;
    int           m_cnt;

    always #5 clk = ~clk;

    div_req_if dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_dividend   (req_dividend),
        .req_divisor    (req_divisor),
        .resp_valid     (resp_valid),
        .resp_ready     (resp_ready),
        .resp_quotient  (resp_quotient),
        .resp_remainder (resp_remainder),
        .resp_dz        (resp_dz),
        .resp_timeout   (resp_timeout),
        .core_dividend  (core_dividend),
        .core_divisor   (core_divisor),
        .core_start     (core_start),
        .core_clr       (core_clr),
        .core_done      (core_done),
        .core_quotient  (core_quotient),
        .core_remainder (core_remainder)
    );

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy         <= 1'b0;
            core_done      <= 1'b0;
            m_cnt          <= 0;
            core_quotient  <= '0;
            core_remainder <= '0;
        end else if (core_clr) begin
            m_busy    <= 1'b0;
            core_done <= 1'b0;
            m_cnt     <= 0;
        end else if (core_start) begin
            if (core_done) begin
                core_done <= 1'b0;
            end else if (!m_busy) begin
                m_busy <= 1'b1;
                m_cnt  <= CORE_LAT;
            end
        end else if (m_busy && !m_never) begin
            if (m_cnt == 1) begin
                m_busy    <= 1'b0;
                core_done <= 1'b1;
                if (core_divisor != '0) begin
                    core_quotient  <= core_dividend / core_divisor;
                    core_remainder <= core_dividend % core_divisor;
                end
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end
    end

    always @(posedge clk) if (!rst && core_start) n_start <= n_start + 1;

    // protocol invariants checked continuously
    logic prev_rv = 1'b0;
    logic prev_rr = 1'b0;
    logic prev_rst = 1'b1;
    always @(negedge clk) begin
        if (!rst && !prev_rst) begin
            if (core_start || core_clr) begin
                checks++;
                assert (!(core_start && core_clr)) else begin
                    failures++;
                    $error("FAIL start_clr_overlap observed=%0b%0b expected=not both", core_start, core_clr);
                end
            end
            if (prev_rv && !prev_rr) begin
                checks++;
                assert (resp_valid === 1'b1) else begin
                    failures++;
                    $error("FAIL resp_valid_hold observed=%0b expected=1", resp_valid);
                end
            end
        end
        prev_rv  = resp_valid;
        prev_rr  = resp_ready;
        prev_rst = rst;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_resp(input int max, output int cnt);
        cnt = 0;
        while (resp_valid !== 1'b1 && cnt < max) begin
            tick();
            cnt++;
        end
        chk("resp_wait_bound", {31'd0, resp_valid}, 32'd1);
    endtask

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        req_valid    = 1'b1;
        req_dividend = a;
        req_divisor  = b;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_dividend = '0; req_divisor = '0;
        resp_ready = 1'b0; m_never = 1'b0;
        tick(); tick();
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_outputs", {27'd0, resp_valid, resp_dz, resp_timeout, core_start, core_clr}, 32'd0);
        chk("rst_data", {resp_quotient, resp_remainder}, 32'd0);
        rst = 1'b0;
        tick();

        // 100 / 7 normal path
        base = n_start;
        chk("t1_ready", {31'd0, req_ready}, 32'd1);
        send(16'd100, 16'd7);
        chk("t1_issue_start", {31'd0, core_start}, 32'd1);
        chk("t1_issue_ready", {31'd0, req_ready}, 32'd0);
        chk("t1_core_operands", {core_dividend, core_divisor}, {16'd100, 16'd7});
        wait_resp(200, k);
        chk("t1_latency", k, 32'd42);
        chk("t1_result", {resp_quotient, resp_remainder}, {16'd14, 16'd2});
        chk("t1_flags", {30'd0, resp_dz, resp_timeout}, 32'd0);
        chk("t1_one_start", n_start - base, 32'd1);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("t1_release_start", {30'd0, core_start, resp_valid}, 32'd2);
        chk("t1_release_ready", {31'd0, req_ready}, 32'd0);
        tick();
        chk("t1_idle", {30'd0, req_ready, core_start}, 32'd2);

        // 0x04D2 / 0 handled locally
        base = n_start;
        send(16'h04D2, 16'h0000);
        chk("t2_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("t2_result", {resp_quotient, resp_remainder}, {16'hFFFF, 16'h04D2});
        chk("t2_flags", {30'd0, resp_dz, resp_timeout}, 32'd2);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("t2_idle", {30'd0, req_ready, core_start}, 32'd2);
        chk("t2_no_start", n_start - base, 32'd0);

        // 0xFFFF / 1 with consumer stalling
        send(16'hFFFF, 16'h0001);
        wait_resp(200, k);
        for (int i = 0; i < 5; i++) begin
            chk("t3_stall_hold", {resp_valid, req_ready, 14'd0, resp_remainder}, {1'b1, 1'b0, 14'd0, 16'h0000});
            chk("t3_stall_quot", {16'd0, resp_quotient}, 32'h0000FFFF);
            tick();
        end
        chk("t3_after_stall", {resp_quotient, resp_remainder}, {16'hFFFF, 16'h0000});
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("t3_release", {31'd0, core_start}, 32'd1);
        tick();

        // core never finishes
        m_never = 1'b1;
        base = n_start;
        send(16'd20, 16'd3);
        chk("t4_issue", {31'd0, core_start}, 32'd1);
        wait_resp(200, k);
        // TIMEOUT WAIT cycles follow the ISSUE cycle
        chk("t4_latency", k, TIMEOUT + 1);
        chk("t4_flags", {30'd0, resp_dz, resp_timeout}, 32'd1);
        chk("t4_result", {resp_quotient, resp_remainder}, 32'd0);
        chk("t4_clr_on", {30'd0, core_clr, core_start}, 32'd2);
        tick();
        chk("t4_clr_off", {30'd0, core_clr, resp_valid}, 32'd1);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("t4_idle_no_release", {30'd0, req_ready, core_start}, 32'd2);
        tick();
        chk("t4_start_count", n_start - base, 32'd1);
        m_never = 1'b0;

        // async reset mid-WAIT
        send(16'd77, 16'd3);
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("t5_async_ready", {31'd0, req_ready}, 32'd1);
        chk("t5_async_outs", {28'd0, resp_valid, core_start, core_clr, resp_timeout}, 32'd0);
        chk("t5_async_operand", {core_dividend, core_divisor}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("t5_ready_after", {31'd0, req_ready}, 32'd1);
        send(16'd50, 16'd5);
        wait_resp(200, k);
        chk("t5_result", {resp_quotient, resp_remainder}, {16'd10, 16'd0});
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        tick();

        // back-to-back 9/2 then 30/4
        send(16'd9, 16'd2);
        wait_resp(200, k);
        chk("t6a_result", {resp_quotient, resp_remainder}, {16'd4, 16'd1});
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        chk("t6_release_start", {31'd0, core_start}, 32'd1);
        tick();
        chk("t6_gap_low", {30'd0, core_start, req_ready}, 32'd1);
        send(16'd30, 16'd4);
        chk("t6_issue_start", {31'd0, core_start}, 32'd1);
        wait_resp(200, k);
        chk("t6b_result", {resp_quotient, resp_remainder}, {16'd7, 16'd2});
        chk("t6b_flags", {30'd0, resp_dz, resp_timeout}, 32'd0);
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        tick();
        chk("t6_final_idle", {31'd0, req_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
